// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a DEPTH-entry prefetch FIFO.
// Issues one word fetch per cycle to a one-cycle-latency instruction memory,
// queues {instruction, fetch address + 1}, and presents the queue head
// downstream. A redirect flushes everything and restarts fetch at a new PC.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_q,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  // DEPTH is a power of two, so plain binary pointers wrap modulo DEPTH.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [31:0]   fetch_pc_r;
  logic [31:0]   issued_pc_r;
  logic          inflight_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   pc_mem_r    [DEPTH];

  logic [OW-1:0] occupancy_s;
  logic          issue_s;
  logic          push_s;
  logic          pop_s;

  // Fetch/push/pop decisions; all of them use registered state only, so a
  // pop in this cycle does not free a slot for this cycle's issue.
  always_comb begin
    occupancy_s = OW'(count_r) + OW'(inflight_r);
    issue_s     = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (redirect) begin
      issue_s = 1'b0;
      push_s  = 1'b0;
      pop_s   = 1'b0;
    end else begin
      issue_s = (occupancy_s < OW'(DEPTH));
      push_s  = inflight_r;
      pop_s   = (count_r != CW'(0)) && !stall;
    end
  end

  // Control state: reset beats redirect, redirect beats push/pop/issue.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_r  <= 32'd0;
      issued_pc_r <= 32'd0;
      inflight_r  <= 1'b0;
      count_r     <= CW'(0);
      rd_ptr_r    <= PW'(0);
      wr_ptr_r    <= PW'(0);
    end else if (redirect) begin
      fetch_pc_r  <= redirect_pc;
      inflight_r  <= 1'b0;
      count_r     <= CW'(0);
      rd_ptr_r    <= PW'(0);
      wr_ptr_r    <= PW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (issue_s) begin
        inflight_r  <= 1'b1;
        issued_pc_r <= fetch_pc_r;
        fetch_pc_r  <= fetch_pc_r + 32'd1;
      end else begin
        inflight_r  <= 1'b0;
      end
    end
  end

  // FIFO storage: capture the returning word with its address + 1.
  always_ff @(posedge clock) begin
    if (!reset && push_s) begin
      instr_mem_r[wr_ptr_r] <= imem_q;
      pc_mem_r[wr_ptr_r]    <= issued_pc_r + 32'd1;
    end
  end

  assign imem_addr   = fetch_pc_r;
  assign instr_valid = (count_r != CW'(0));

  // Head presentation from registered storage only; zeros when empty.
  always_comb begin
    if (instr_valid) begin
      instr    = instr_mem_r[rd_ptr_r];
      instr_pc = pc_mem_r[rd_ptr_r];
    end else begin
      instr    = 32'd0;
      instr_pc = 32'd0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a
// queue-based reference model of the fetch/flush rules.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_q;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int checks;
  int failures;

  // Reference model state
  logic [63:0] mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_issued;
  bit          m_inflight;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory: word a holds a + 0x100, one cycle read latency.
  always_ff @(posedge clock) imem_q <= imem_addr + 32'h100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    e_instr = 32'd0;
    e_pc    = 32'd0;
    if (mq.size() != 0) begin
      e_instr = mq[0][63:32];
      e_pc    = mq[0][31:0];
    end
    chk("model_imem_addr", imem_addr, m_fetch);
    chk("model_valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
    chk("model_instr", instr, e_instr);
    chk("model_instr_pc", instr_pc, e_pc);
  endtask

  task automatic model_step(input bit r, input bit rd, input logic [31:0] rpc, input bit st);
    int occ;
    if (r) begin
      m_fetch = 32'd0;
      mq.delete();
      m_inflight = 1'b0;
    end else if (rd) begin
      m_fetch = rpc;
      mq.delete();
      m_inflight = 1'b0;
    end else begin
      occ = mq.size() + int'(m_inflight);
      if (mq.size() > 0 && !st) void'(mq.pop_front());
      if (m_inflight) mq.push_back({m_issued + 32'h100, m_issued + 32'd1});
      if (occ < DEPTH) begin
        m_issued   = m_fetch;
        m_fetch    = m_fetch + 32'd1;
        m_inflight = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, clock it.
  task automatic tick(input bit r, input bit rd, input logic [31:0] rpc, input bit st);
    reset       = r;
    redirect    = rd;
    redirect_pc = rpc;
    stall       = st;
    #1;
    check_model();
    @(posedge clock);
    model_step(r, rd, rpc, st);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    stall       = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    model_step(1'b1, 1'b0, 32'd0, 1'b0);

    // Reset state
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);

    // Streaming after reset: first head two cycles after release
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    chk("stream_first_instr", instr, 32'h100);
    chk("stream_first_pc", instr_pc, 32'd1);
    for (int k = 2; k <= 6; k++) begin
      tick(1'b0, 1'b0, 32'd0, 1'b0);
      chk("stream_pc", instr_pc, 32'(k));
      chk("stream_valid", {31'd0, instr_valid}, 32'd1);
    end

    // Stall from reset release for 10 cycles, then drain without bubbles
    tick(1'b1, 1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 32'd0, 1'b1);
    chk("stall_imem_addr", imem_addr, 32'd4);
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      chk("drain_pc", instr_pc, 32'(k));
      tick(1'b0, 1'b0, 32'd0, 1'b0);
    end

    // Redirect with three queued entries and one in flight
    tick(1'b1, 1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 32'd0, 1'b1);
    tick(1'b0, 1'b1, 32'h40, 1'b0);
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_imem_addr", imem_addr, 32'h40);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    chk("redir_pc", instr_pc, 32'h41);
    chk("redir_instr", instr, 32'h140);

    // Redirect to the last word address: fetch wraps to zero
    tick(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFF);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    chk("wrap_addr1", imem_addr, 32'd0);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    chk("wrap_pc0", instr_pc, 32'd0);
    chk("wrap_instr0", instr, 32'hFF);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    chk("wrap_pc1", instr_pc, 32'd1);

    // Reset coincident with redirect on a full queue
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 32'd0, 1'b1);
    tick(1'b1, 1'b1, 32'h80, 1'b1);
    chk("rstredir_addr", imem_addr, 32'd0);
    chk("rstredir_valid", {31'd0, instr_valid}, 32'd0);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 32'd0, 1'b0);

    // Redirect while push and pop are both active
    tick(1'b0, 1'b1, 32'h200, 1'b0);
    chk("pushpop_redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("pushpop_redir_addr", imem_addr, 32'h200);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    chk("pushpop_redir_pc", instr_pc, 32'h201);
    chk("pushpop_redir_instr", instr, 32'h300);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit          r_r;
      bit          r_rd;
      bit          r_st;
      logic [31:0] r_pc;
      r_r  = ($urandom_range(0, 99) == 0);
      r_rd = ($urandom_range(0, 19) == 0);
      r_st = ($urandom_range(0, 9) < 3);
      r_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                         : 32'($urandom);
      tick(r_r, r_rd, r_pc, r_st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of 2, range 2..16.
REQ-002 SHALL have clock  input  1  master clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have imem_addr  output  32  word address to instruction memory; imem read latency is one cycle.
REQ-005 SHALL have imem_q  input  32  instruction word for the address presented in the previous cycle.
REQ-006 SHALL have stall  input  1  downstream (FD latch) cannot accept this cycle.
REQ-007 SHALL have redirect  input  1  branch/jump taken; flush and refetch.
REQ-008 SHALL have redirect_pc  input  32  target word address for redirect.
REQ-009 SHALL have instr  output  32  head instruction; 32'b0 (nop) when instr_valid=0.
REQ-010 SHALL have instr_pc  output  32  head fetch address + 1 (mod 2^32); 32'b0 when instr_valid=0.
REQ-011 SHALL have instr_valid  output  1  queue head holds a valid instruction.

Function
REQ-012 SHALL hold fetch_pc, DEPTH-entry FIFO of {instr, pc+1}, count (0..DEPTH), inflight bit; imem_addr = fetch_pc combinationally.
REQ-013 SHALL issue a fetch in a cycle iff redirect=0 and (count + inflight) < DEPTH, using registered values only (same-cycle pop not credited).
REQ-014 On issue SHALL set inflight=1 and increment fetch_pc by 1 at the edge, wrapping 32'hFFFFFFFF -> 0; without issue, fetch_pc and imem_addr SHALL hold.
REQ-015 SHALL clear inflight at the edge when no issue occurs; inflight set means imem_q is valid in that cycle.
REQ-016 When inflight=1 and redirect=0, SHALL push {imem_q, issued address + 1} at the edge; count never exceeds DEPTH given REQ-013.
REQ-017 Pop SHALL occur at the edge when instr_valid=1 and stall=0 and redirect=0; push and pop in the same cycle SHALL leave count unchanged.
REQ-018 Output SHALL come only from the registered FIFO head (no imem_q bypass); order SHALL equal fetch order.
REQ-019 Read/write pointers SHALL wrap modulo DEPTH; full (count=DEPTH) and empty (count=0) SHALL be distinguished by count, not pointers.
REQ-020 On redirect=1 at an edge SHALL: clear FIFO and count, clear inflight, discard imem_q of that cycle, set fetch_pc=redirect_pc, issue nothing that cycle.
REQ-021 Redirect SHALL take priority over push, pop and issue in the same cycle; a head presented in the redirect cycle is considered flushed.
REQ-022 Redirect latency: redirect in cycle R -> imem_addr=redirect_pc in R+1, instr_valid=1 with instr_pc=redirect_pc+1 in R+2.
REQ-023 Sustained throughput with stall=0 SHALL be one instruction per cycle for DEPTH>=2.
REQ-024 Stall SHALL never drop or duplicate an entry; when stall deasserts, held entries SHALL drain one per cycle without bubbles.

Reset
REQ-025 While reset=1 at an edge: fetch_pc=0, count=0, pointers=0, inflight=0; reset SHALL override redirect, push, pop and issue.
REQ-026 Outputs in the cycle after reset: imem_addr=0, instr=0, instr_pc=0, instr_valid=0.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight instructions; first post-reset instr_valid SHALL be the second cycle after reset deasserts, instr_pc=1.

Verification
REQ-028 Reset, stall=0, imem[a]=a+32'h100 -> cycle 2 after reset: instr=32'h100, instr_pc=1; then instr_pc 2,3,4,... every cycle, no gaps.
REQ-029 Stall held 10 cycles from reset release -> addresses 0..3 fetched, imem_addr stays 4, count=4; release -> instr_pc 1,2,3,4,5 in consecutive cycles.
REQ-030 Redirect to 32'h40 with count=3, inflight=1 -> R+1 instr_valid=0, imem_addr=32'h40; R+2 instr_pc=32'h41, instr=imem[32'h40]; no old entry ever appears.
REQ-031 Redirect to 32'hFFFFFFFF -> imem_addr FFFFFFFF then 0; instr_pc 0 then 1.
REQ-032 reset=1 coincident with redirect=1 to 32'h80 and full queue -> next cycle imem_addr=0, instr_valid=0; redirect target never fetched.
REQ-033 Redirect coincident with pop and push -> pointers and count reset to 0, popped head not re-presented, pushed word discarded.
